// File: rtl/scan_onehot_decoder.sv
// -----------------------------------------------------------------------------
// scan_onehot_decoder
//
// Registered one-hot decoder with a self-sequencing scan mode. It replaces the
// old cascaded 4-to-16 combinational decoder wherever the outputs must walk
// on their own (display digit muxing, row strobes, chip selects).
//
// Modes (chosen every cycle from en/mode):
//   OFF    : en=0. Outputs low. idx and the dwell counter keep their values.
//   DIRECT : en=1, mode=0. sel is registered and decoded, one cycle latency.
//   SCAN   : en=1, mode=1. idx walks 0..limit. Each position is held for
//            DWELL cycles. Entering SCAN, or pulsing load, reloads idx from sel.
//
// Ports:
//   clk    in   system clock, rising edge
//   n_rst  in   synchronous active-low reset
//   en     in   global enable
//   mode   in   0 = DIRECT, 1 = SCAN
//   load   in   SCAN reload strobe (idx <= sel)
//   sel    in   DIRECT index / SCAN start index
//   limit  in   SCAN last index before wrapping to 0
//   f      out  one-hot decode of idx, all-zero when OFF
//   idx    out  currently decoded index
//   wrap   out  one-cycle pulse on the cycle idx wraps limit -> 0
//
// All outputs come straight from flops. There is no combinational input to
// output path.
// -----------------------------------------------------------------------------
module scan_onehot_decoder #(
  parameter int SEL_W = 4,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      sel,
  input  logic [SEL_W-1:0]      limit,
  output logic [(2**SEL_W)-1:0] f,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int OUT_W = 2 ** SEL_W;
  // Give the counter at least one bit so that DWELL=1 still has a legal vector.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  localparam logic [1:0] ST_OFF    = 2'b00;
  localparam logic [1:0] ST_DIRECT = 2'b01;
  localparam logic [1:0] ST_SCAN   = 2'b10;

  logic [1:0]       state_r;
  logic [SEL_W-1:0] idx_r;
  logic [CNT_W-1:0] dwell_r;
  logic             wrap_r;
  logic [OUT_W-1:0] f_r;

  logic [1:0]       state_nxt_s;
  logic [SEL_W-1:0] idx_nxt_s;
  logic [CNT_W-1:0] dwell_nxt_s;
  logic             wrap_nxt_s;
  logic [OUT_W-1:0] f_nxt_s;

  // Binary index to one-hot vector.
  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] v;
    v    = {OUT_W{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

  // Next-state selection: en has priority over mode.
  always_comb begin
    state_nxt_s = ST_OFF;
    if (!en) begin
      state_nxt_s = ST_OFF;
    end else if (!mode) begin
      state_nxt_s = ST_DIRECT;
    end else begin
      state_nxt_s = ST_SCAN;
    end
  end

  // Index, dwell and wrap updates for the state being entered this edge.
  always_comb begin
    idx_nxt_s   = idx_r;
    dwell_nxt_s = dwell_r;
    wrap_nxt_s  = 1'b0;
    case (state_nxt_s)
      ST_DIRECT: begin
        idx_nxt_s   = sel;
        dwell_nxt_s = {CNT_W{1'b0}};
      end
      ST_SCAN: begin
        // Entry from any other state and load are the same: restart at sel.
        // load also beats an advance on the same cycle.
        if ((state_r != ST_SCAN) || load) begin
          idx_nxt_s   = sel;
          dwell_nxt_s = {CNT_W{1'b0}};
        end else if (dwell_r == DWELL_LAST) begin
          dwell_nxt_s = {CNT_W{1'b0}};
          // Use >= rather than == so that a start index above limit wraps
          // instead of running away. It also stops idx+1 from overflowing.
          if (idx_r >= limit) begin
            idx_nxt_s  = {SEL_W{1'b0}};
            wrap_nxt_s = 1'b1;
          end else begin
            idx_nxt_s  = idx_r + SEL_W'(1'b1);
          end
        end else begin
          dwell_nxt_s = dwell_r + CNT_W'(1'b1);
        end
      end
      default: begin
        // OFF, plus recovery from the unused encoding: hold index and counter.
        idx_nxt_s   = idx_r;
        dwell_nxt_s = dwell_r;
      end
    endcase
  end

  // Output decode from the next registered values, so f lines up with idx.
  always_comb begin
    f_nxt_s = {OUT_W{1'b0}};
    if ((state_nxt_s == ST_DIRECT) || (state_nxt_s == ST_SCAN)) begin
      f_nxt_s = onehot(idx_nxt_s);
    end else begin
      f_nxt_s = {OUT_W{1'b0}};
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r <= ST_OFF;
      idx_r   <= {SEL_W{1'b0}};
      dwell_r <= {CNT_W{1'b0}};
      wrap_r  <= 1'b0;
      f_r     <= {OUT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      dwell_r <= dwell_nxt_s;
      wrap_r  <= wrap_nxt_s;
      f_r     <= f_nxt_s;
    end
  end

  assign f    = f_r;
  assign idx  = idx_r;
  assign wrap = wrap_r;

endmodule
